// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: valid/ready word in, one bit per clk out.
// Optional even-parity trailer bit is compiled in with `define PARITY_EN.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 2);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           r_state, w_state;
    logic [CW-1:0]    r_cnt, w_cnt;
    logic [WIDTH-1:0] r_sreg, w_sreg;
    logic             r_dout, w_dout;
    logic             r_dvld, w_dvld;
    logic             r_fs, w_fs;
    logic             w_last_data;
`ifdef PARITY_EN
    logic             r_par, w_par;
`endif

    function automatic logic first_bit(input logic [WIDTH-1:0] s);
        return MSB_FIRST ? s[WIDTH-1] : s[0];
    endfunction

    // Drops the bit just sent so the next one sits at the output end.
    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] s);
        return MSB_FIRST ? {s[WIDTH-2:0], 1'b0} : {1'b0, s[WIDTH-1:1]};
    endfunction

    assign w_last_data = (r_cnt == CW'(WIDTH));

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_sreg   = r_sreg;
        w_dout   = 1'b0;
        w_dvld   = 1'b0;
        w_fs     = 1'b0;
        in_ready = 1'b0;
`ifdef PARITY_EN
        w_par    = r_par;
`endif
        case (r_state)
            IDLE: in_ready = 1'b1;
            SHIFT: begin
                if (!w_last_data) begin
                    w_dout = first_bit(r_sreg);
                    w_sreg = shift_out(r_sreg);
                    w_dvld = 1'b1;
                    w_cnt  = r_cnt + CW'(1);
                end else begin
`ifdef PARITY_EN
                    w_state = PAR;
                    w_dout  = r_par;
                    w_dvld  = 1'b1;
                    w_cnt   = r_cnt + CW'(1);
`else
                    in_ready = 1'b1;
                    w_state  = IDLE;
                    w_cnt    = '0;
`endif
                end
            end
`ifdef PARITY_EN
            PAR: begin
                in_ready = 1'b1;
                w_state  = IDLE;
                w_cnt    = '0;
            end
`endif
            default: begin
                w_state = IDLE;
                w_cnt   = '0;
            end
        endcase
        // A new word overrides the idle/wrap-up decision, giving zero-gap streaming.
        if (in_valid && in_ready) begin
            w_state = SHIFT;
            w_cnt   = CW'(1);
            w_dout  = first_bit(in_data);
            w_sreg  = shift_out(in_data);
            w_dvld  = 1'b1;
            w_fs    = 1'b1;
`ifdef PARITY_EN
            w_par   = ^in_data;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_sreg <= '0;
            r_dout <= 1'b0;
            r_dvld <= 1'b0;
            r_fs   <= 1'b0;
`ifdef PARITY_EN
            r_par  <= 1'b0;
`endif
        end else begin
            r_cnt  <= w_cnt;
            r_sreg <= w_sreg;
            r_dout <= w_dout;
            r_dvld <= w_dvld;
            r_fs   <= w_fs;
`ifdef PARITY_EN
            r_par  <= w_par;
`endif
        end
    end

    assign dout        = r_dout;
    assign dout_valid  = r_dvld;
    assign frame_start = r_fs;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: unit 0 is MSB-first, unit 1 LSB-first, both WIDTH=8.
module tb_piso_serializer;

`ifdef PARITY_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iv[2];
    logic [7:0] id[2];
    logic       rdy[2], dout[2], dvld[2], fs[2], bsy[2];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]), .in_data(id[0]),
        .dout(dout[0]), .dout_valid(dvld[0]), .frame_start(fs[0]), .busy(bsy[0]));

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]), .in_data(id[1]),
        .dout(dout[1]), .dout_valid(dvld[1]), .frame_start(fs[1]), .busy(bsy[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int u, input string tag);
        chk($sformatf("%s u%0d dout", tag, u), 32'(dout[u]), 0);
        chk($sformatf("%s u%0d dout_valid", tag, u), 32'(dvld[u]), 0);
        chk($sformatf("%s u%0d frame_start", tag, u), 32'(fs[u]), 0);
        chk($sformatf("%s u%0d busy", tag, u), 32'(bsy[u]), 0);
        chk($sformatf("%s u%0d in_ready", tag, u), 32'(rdy[u]), 1);
    endtask

    // Called on a negedge; offers d and steps to the negedge after acceptance.
    task automatic start(input int u, input logic [7:0] d);
        iv[u] = 1'b1;
        id[u] = d;
        chk($sformatf("start u%0d in_ready", u), 32'(rdy[u]), 1);
        @(negedge clk);
    endtask

    // Checks every bit of an accepted frame; inputs nv/nd are offered from the
    // first bit cycle on, so nv=1 chains the next word on the last bit.
    task automatic run_frame(input int u, input logic [7:0] d, input logic nv,
                             input logic [7:0] nd, input int stop_at);
        logic [7:0] w;
        logic       expb;
        w = d;
        for (int i = 1; i <= FLEN; i++) begin
            expb = (i > 8) ? ^w : (u == 1 ? w[i-1] : w[8-i]);
            chk($sformatf("u%0d %02h bit%0d dout", u, d, i), 32'(dout[u]), 32'(expb));
            chk($sformatf("u%0d %02h bit%0d dout_valid", u, d, i), 32'(dvld[u]), 1);
            chk($sformatf("u%0d %02h bit%0d frame_start", u, d, i), 32'(fs[u]), 32'(i == 1));
            chk($sformatf("u%0d %02h bit%0d busy", u, d, i), 32'(bsy[u]), 1);
            chk($sformatf("u%0d %02h bit%0d in_ready", u, d, i), 32'(rdy[u]), 32'(i == FLEN));
            if (i == stop_at) return;
            iv[u] = nv;
            id[u] = nd;
            @(negedge clk);
        end
    endtask

    initial begin
        iv[0] = 1'b0; iv[1] = 1'b0;
        id[0] = 8'h00; id[1] = 8'h00;

        // Reset held for 3 clocks
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle(0, "reset");
        chk_idle(1, "reset");

        // Single MSB-first frame, then idle
        start(0, 8'hA5);
        run_frame(0, 8'hA5, 1'b0, 8'h00, 0);
        chk_idle(0, "after A5");

        // Back-to-back A5, 3C
        start(0, 8'hA5);
        run_frame(0, 8'hA5, 1'b1, 8'h3C, 0);
        run_frame(0, 8'h3C, 1'b0, 8'h00, 0);
        chk_idle(0, "after 3C");

        // LSB-first; in_data changed after accept must not leak into the frame
        start(1, 8'h01);
        run_frame(1, 8'h01, 1'b0, 8'hFF, 0);
        chk_idle(1, "after 01");

        // Parity value 1 case (and another plain frame otherwise)
        start(0, 8'h07);
        run_frame(0, 8'h07, 1'b0, 8'h00, 0);
        chk_idle(0, "after 07");

        // Abort after the third bit
        start(0, 8'hA5);
        run_frame(0, 8'hA5, 1'b0, 8'h00, 3);
        iv[0] = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_idle(0, "async reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle(0, "post reset");
        start(0, 8'h3C);
        run_frame(0, 8'h3C, 1'b0, 8'h00, 0);
        chk_idle(0, "fresh frame");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
